// File: rtl/o_feature_writeback_pkg.sv
// Shared constants, state encoding and requantization helper for the CLP
// output feature writeback block.
package o_feature_writeback_pkg;

    localparam int FEATURE_WIDTH = 16;
    localparam int SCALER_WIDTH  = 16;
    localparam int OUT_BUS_WIDTH = 128;
    localparam int FIFO_DEPTH    = 4;
    localparam int PROD_WIDTH    = FEATURE_WIDTH + SCALER_WIDTH;
    localparam int EXT_WIDTH     = PROD_WIDTH + 1;
    localparam int LANES         = OUT_BUS_WIDTH / FEATURE_WIDTH;
    localparam int LANE_W        = $clog2(LANES);

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_RUN   = 2'd1,
        WB_DRAIN = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_e;

    localparam logic signed [EXT_WIDTH-1:0] SAT_HI = EXT_WIDTH'((2 ** (FEATURE_WIDTH - 1)) - 1);
    localparam logic signed [EXT_WIDTH-1:0] SAT_LO = -EXT_WIDTH'(2 ** (FEATURE_WIDTH - 1));

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [FEATURE_WIDTH-1:0] requant(
        input logic [PROD_WIDTH-1:0] x,
        input logic [4:0]            sh,
        input logic                  relu
    );
        logic signed [EXT_WIDTH-1:0] v;
        v = signed'({x[PROD_WIDTH-1], x});
        if (sh != 5'd0)
            v = v + (EXT_WIDTH'(1) << (sh - 5'd1));
        v = v >>> sh;
        if (v > SAT_HI)
            v = SAT_HI;
        else if (v < SAT_LO)
            v = SAT_LO;
        if (relu && v[EXT_WIDTH-1])
            v = '0;
        return v[FEATURE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/o_feature_writeback_fifo.sv
// Packed-word FIFO between the lane packer and the output memory port.
// Registered full/empty flags; push and pop may happen in the same cycle.
module wb_word_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && !empty;
    assign do_push   = push && !full;
    assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/o_feature_writeback.sv
// Requantizes CLP scaled features, packs LANES per bus word and streams the
// words to output feature memory at consecutive addresses.
module o_feature_writeback
    import o_feature_writeback_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_enable,
    input  logic [15:0]              dst_addr,
    input  logic [7:0]               word_count,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    input  logic [PROD_WIDTH-1:0]    in_feature,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_BUS_WIDTH-1:0] o_wr_data,
    output logic [15:0]              o_wr_addr,
    output logic                     o_wr_en,
    input  logic                     o_wr_ready,
    output logic                     wb_busy,
    output logic                     wb_done
);
    wb_state_e state, state_nxt;

    logic [15:0] base_addr;
    logic [7:0]  wc;
    logic [4:0]  shift_q;
    logic        relu_q;
    logic [7:0]  words_packed;
    logic [7:0]  words_written;
    logic [LANE_W-1:0] lane;
    logic [LANES-1:0][FEATURE_WIDTH-1:0] pack_reg;
    logic [LANES-1:0][FEATURE_WIDTH-1:0] push_word;

    logic [FEATURE_WIDTH-1:0] feat;
    logic accept, last_lane, push, pop, fifo_full, fifo_empty, start;

    assign start     = (state == WB_IDLE) && wb_enable;
    assign in_ready  = (state == WB_RUN) && !fifo_full && (words_packed < wc);
    assign accept    = in_valid && in_ready;
    assign feat      = requant(in_feature, shift_q, relu_q);
    assign last_lane = (lane == LANE_W'(LANES - 1));
    assign push      = accept && last_lane;
    assign o_wr_en   = !fifo_empty;
    assign pop       = o_wr_en && o_wr_ready;
    assign o_wr_addr = base_addr + {8'd0, words_written};
    assign wb_busy   = (state != WB_IDLE);
    assign wb_done   = (state == WB_DONE);

    // The final lane bypasses the pack register so the word enters the FIFO
    // in the same cycle it completes.
    always_comb begin
        push_word            = pack_reg;
        push_word[LANES-1]   = feat;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE:  if (wb_enable) state_nxt = (word_count == 8'd0) ? WB_DONE : WB_RUN;
            WB_RUN:   if (words_packed == wc) state_nxt = WB_DRAIN;
            WB_DRAIN: if (words_written == wc) state_nxt = WB_DONE;
            WB_DONE:  state_nxt = WB_IDLE;
            default:  state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= WB_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_addr     <= '0;
            wc            <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            words_packed  <= '0;
            words_written <= '0;
            lane          <= '0;
            pack_reg      <= '0;
        end else begin
            if (start) begin
                base_addr     <= dst_addr;
                wc            <= word_count;
                shift_q       <= shift;
                relu_q        <= relu_en;
                words_packed  <= '0;
                words_written <= '0;
                lane          <= '0;
                pack_reg      <= '0;
            end else begin
                if (accept) begin
                    if (last_lane) begin
                        lane         <= '0;
                        pack_reg     <= '0;
                        words_packed <= words_packed + 8'd1;
                    end else begin
                        lane           <= lane + 1'b1;
                        pack_reg[lane] <= feat;
                    end
                end
                if (pop)
                    words_written <= words_written + 8'd1;
            end
        end
    end

    wb_word_fifo #(
        .WIDTH (OUT_BUS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (o_wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_o_feature_writeback.sv
// Directed bench for o_feature_writeback: packing, requantization,
// backpressure, address wrap, start/ignore rules and async reset.
module tb_o_feature_writeback;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_enable;
    logic [15:0]  dst_addr;
    logic [7:0]   word_count;
    logic [4:0]   shift;
    logic         relu_en;
    logic [31:0]  in_feature;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] o_wr_data;
    logic [15:0]  o_wr_addr;
    logic         o_wr_en;
    logic         o_wr_ready;
    logic         wb_busy;
    logic         wb_done;

    always #5 clk = ~clk;

    o_feature_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .wb_enable  (wb_enable),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .shift      (shift),
        .relu_en    (relu_en),
        .in_feature (in_feature),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .o_wr_data  (o_wr_data),
        .o_wr_addr  (o_wr_addr),
        .o_wr_en    (o_wr_en),
        .o_wr_ready (o_wr_ready),
        .wb_busy    (wb_busy),
        .wb_done    (wb_done)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observers: write log, accepted features, done pulses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0]  wa_q [$];
    logic [127:0] wd_q [$];
    int n_acc = 0, n_done = 0, last_acc = 0, done_at = 0;

    always @(negedge clk) begin
        if (rst && o_wr_en && o_wr_ready) begin
            wa_q.push_back(o_wr_addr);
            wd_q.push_back(o_wr_data);
        end
        if (rst && in_valid && in_ready) begin
            n_acc++;
            last_acc = cyc;
        end
        if (rst && wb_done) begin
            n_done++;
            done_at = cyc;
        end
    end

    function automatic logic [127:0] word_of(input int b);
        logic [127:0] w;
        for (int k = 0; k < 8; k++)
            w[k*16 +: 16] = 16'(b + k);
        return w;
    endfunction

    task automatic start(input logic [15:0] a, input logic [7:0] n, input logic [4:0] s, input logic r);
        @(posedge clk); #1;
        wb_enable = 1'b1; dst_addr = a; word_count = n; shift = s; relu_en = r;
        @(posedge clk); #1;
        wb_enable = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        int t = 0;
        in_valid = 1'b1;
        in_feature = v;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", t < 200, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (n_done == d0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", t < 300, 1'b1);
        @(negedge clk);
    endtask

    logic [31:0] rq_in [8] = '{32'd24, 32'hFFFF_FFE8, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'd7, 32'd8, 32'hFFFF_FFF8, 32'hFFFF_FFF7};

    int a0, acc0, d0;
    logic [127:0] held;

    initial begin
        rst = 1'b0; wb_enable = 1'b0; dst_addr = '0; word_count = '0; shift = '0;
        relu_en = 1'b0; in_feature = '0; in_valid = 1'b0; o_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", o_wr_en, 1'b0);
        chk("rst_wr_data", o_wr_data, 128'd0);
        chk("rst_wr_addr", o_wr_addr, 16'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", wb_busy, 1'b0);
        chk("rst_done", wb_done, 1'b0);
        rst = 1'b1;

        // Basic run
        a0 = wa_q.size(); acc0 = n_acc; d0 = n_done;
        start(16'h0010, 8'd2, 5'd0, 1'b0);
        chk("basic_busy", wb_busy, 1'b1);
        for (int i = 1; i <= 16; i++) send(32'(i));
        wait_done(d0);
        chk("basic_nwr", wa_q.size() - a0, 2);
        chk("basic_addr0", wa_q[a0], 16'h0010);
        chk("basic_data0", wd_q[a0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("basic_addr1", wa_q[a0+1], 16'h0011);
        chk("basic_data1", wd_q[a0+1], 128'h0010_000F_000E_000D_000C_000B_000A_0009);
        chk("basic_nacc", n_acc - acc0, 16);
        chk("basic_ndone", n_done - d0, 1);
        chk("basic_latency", done_at - last_acc, 3);
        chk("basic_idle", wb_busy, 1'b0);

        // Rounding and saturation
        a0 = wa_q.size(); d0 = n_done;
        start(16'h0100, 8'd1, 5'd4, 1'b0);
        for (int i = 0; i < 8; i++) send(rq_in[i]);
        wait_done(d0);
        chk("rq_nwr", wa_q.size() - a0, 1);
        chk("rq_data", wd_q[a0], 128'hFFFF_0000_0001_0000_8000_7FFF_FFFF_0002);

        // ReLU on the same vectors
        a0 = wa_q.size(); d0 = n_done;
        start(16'h0101, 8'd1, 5'd4, 1'b1);
        for (int i = 0; i < 8; i++) send(rq_in[i]);
        wait_done(d0);
        chk("relu_addr", wa_q[a0], 16'h0101);
        chk("relu_data", wd_q[a0], 128'h0000_0000_0001_0000_0000_7FFF_0000_0002);

        // Backpressure: memory stalled while features stream in
        o_wr_ready = 1'b0;
        a0 = wa_q.size(); acc0 = n_acc; d0 = n_done;
        start(16'h0200, 8'd6, 5'd0, 1'b0);
        fork
            for (int i = 0; i < 48; i++) send(32'(i + 1));
            begin
                repeat (20) @(negedge clk);
                held = o_wr_data;
                chk("bp_wr_en", o_wr_en, 1'b1);
                chk("bp_head0", held, word_of(1));
                chk("bp_addr20", o_wr_addr, 16'h0200);
                repeat (20) @(negedge clk);
                chk("bp_packed", n_acc - acc0, 32);
                chk("bp_in_ready", in_ready, 1'b0);
                chk("bp_stable_data", o_wr_data, held);
                chk("bp_stable_addr", o_wr_addr, 16'h0200);
                chk("bp_no_wr", wa_q.size() - a0, 0);
                @(posedge clk); #1;
                o_wr_ready = 1'b1;
            end
        join
        wait_done(d0);
        chk("bp_nwr", wa_q.size() - a0, 6);
        for (int w = 0; w < 6; w++) begin
            chk("bp_addr", wa_q[a0+w], 16'(16'h0200 + w));
            chk("bp_data", wd_q[a0+w], word_of(w * 8 + 1));
        end

        // Zero-length job
        a0 = wa_q.size(); d0 = n_done;
        start(16'h0300, 8'd0, 5'd0, 1'b0);
        chk("zero_done", wb_done, 1'b1);
        repeat (4) @(negedge clk);
        chk("zero_ndone", n_done - d0, 1);
        chk("zero_nwr", wa_q.size() - a0, 0);
        chk("zero_wr_en", o_wr_en, 1'b0);

        // Address wrap, with a start pulse during RUN that must be ignored
        a0 = wa_q.size(); d0 = n_done;
        start(16'hFFFF, 8'd2, 5'd0, 1'b0);
        for (int i = 1; i <= 3; i++) send(32'(i));
        start(16'h1234, 8'd0, 5'd3, 1'b1);
        for (int i = 4; i <= 16; i++) send(32'(i));
        wait_done(d0);
        chk("wrap_nwr", wa_q.size() - a0, 2);
        chk("wrap_addr0", wa_q[a0], 16'hFFFF);
        chk("wrap_addr1", wa_q[a0+1], 16'h0000);
        chk("wrap_data0", wd_q[a0], word_of(1));
        chk("wrap_data1", wd_q[a0+1], word_of(9));
        chk("wrap_ndone", n_done - d0, 1);

        // Async reset mid-run, then a fresh job
        o_wr_ready = 1'b0;
        start(16'h0300, 8'd2, 5'd0, 1'b0);
        for (int i = 1; i <= 11; i++) send(32'(i + 100));
        chk("mid_wr_en", o_wr_en, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_wr_en", o_wr_en, 1'b0);
        chk("mr_wr_data", o_wr_data, 128'd0);
        chk("mr_wr_addr", o_wr_addr, 16'd0);
        chk("mr_in_ready", in_ready, 1'b0);
        chk("mr_busy", wb_busy, 1'b0);
        chk("mr_done", wb_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        o_wr_ready = 1'b1;
        a0 = wa_q.size(); d0 = n_done;
        start(16'h0400, 8'd1, 5'd0, 1'b0);
        for (int i = 0; i < 8; i++) send(32'(32'h21 + i));
        wait_done(d0);
        chk("mr_nwr", wa_q.size() - a0, 1);
        chk("mr_addr", wa_q[a0], 16'h0400);
        chk("mr_data", wd_q[a0], word_of(32'h21));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/o_feature_writeback.md
Name: o_feature_writeback

Overview:
- Downstream consumer of the CLP datapath's scaled_feature stream.
- Requantizes each scaled product to FEATURE_WIDTH and packs LANES results into one output-bus word.
- Buffers the packed words in a small FIFO and writes them to the output feature memory at consecutive addresses under ready/valid backpressure.
- Started by the instruction decoder; reports completion with a one-cycle done pulse that is OR-ed into the execution-state flag, like the fetchers.

Parameters:
- FEATURE_WIDTH, 16, output feature width (signed).
- SCALER_WIDTH, 16; the input product is FEATURE_WIDTH+SCALER_WIDTH bits signed.
- OUT_BUS_WIDTH, 128, output memory data width.
- LANES, OUT_BUS_WIDTH/FEATURE_WIDTH (8), features per word.
- FIFO_DEPTH, 4, packed-word FIFO depth (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wb_enable  in  1  start pulse from decoder.
- dst_addr  in  16  base word address in output memory.
- word_count  in  8  number of words to write.
- shift  in  5  right-shift amount for requantization.
- relu_en  in  1  clamp negative results to 0.
- in_feature  in  FEATURE_WIDTH+SCALER_WIDTH  scaled_feature from the CLP.
- in_valid  in  1  in_feature valid.
- in_ready  out  1  block accepts in_feature.
- o_wr_data  out  OUT_BUS_WIDTH  packed word.
- o_wr_addr  out  16  write address.
- o_wr_en  out  1  write request (valid).
- o_wr_ready  in  1  memory accepts the write.
- wb_busy  out  1  state is not IDLE.
- wb_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, pack register and FIFO cleared; all outputs 0. Partial words and FIFO contents are discarded, including when reset arrives mid-operation.
- States:
  - IDLE: on wb_enable, latch dst_addr, word_count, shift and relu_en. Go to DONE if word_count==0, else go to RUN.
  - RUN: accept features. Go to DRAIN once words_packed==word_count.
  - DRAIN: write the remaining FIFO contents. Go to DONE when words_written==word_count.
  - DONE: wb_done=1 for one cycle, then IDLE.
- wb_enable outside IDLE is ignored.
- in_ready = (state==RUN) && !fifo_full && (words_packed<word_count).
  - fifo_full is the registered full flag; a same-cycle pop does not raise in_ready.
- Requantization, on an accepted feature x (signed, FEATURE_WIDTH+SCALER_WIDTH bits):
  - Sign-extend x by 1 bit.
  - If shift>0, add 1<<(shift-1) (round half up), then arithmetic shift right by shift.
  - Saturate to [-2^(FW-1), 2^(FW-1)-1].
  - If relu_en and the result is negative, the result is 0.
  - Purely combinational before the pack register.
- Packing:
  - lane counter runs 0..LANES-1; lane k occupies bits [k*FW +: FW], so lane 0 is the LSBs.
  - On accepting lane LANES-1, the full word (pack register plus current lane) is pushed into the FIFO in the same cycle. The lane counter returns to 0 and words_packed increments.
- Write side:
  - o_wr_en = !fifo_empty, in any state.
  - o_wr_data is the FIFO head; o_wr_data and o_wr_addr stay stable while o_wr_en && !o_wr_ready.
  - On o_wr_en && o_wr_ready: pop, words_written++.
  - o_wr_addr = base + words_written, modulo 2^16 (wraps from 0xFFFF to 0x0000).
- FIFO supports simultaneous push and pop in any non-full state. Push while full is impossible by construction; pop while empty is blocked.
- Latency: the last lane accepted in cycle t appears on o_wr_en in cycle t+1. If memory is always ready, wb_done asserts in cycle t+3 after the final lane.
- The last word is exactly one full word; no partial-word flush exists. word_count*LANES features are consumed.

Decomposition:
- Shared package (network_para.vh style):
  - LANES derivation.
  - State encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - Requantization saturation limits.
- One sub-module, wb_word_fifo: FIFO_DEPTH x OUT_BUS_WIDTH synchronous FIFO with registered full/empty flags, async active-low reset, and simultaneous push/pop.

Test Plan:
- Basic run: dst_addr=0x0010, word_count=2, shift=0, inputs 1..16, always ready.
  - Required: writes at 0x0010 then 0x0011.
  - Word 0 lane k = k+1, i.e. 0x0008_0007_..._0001.
  - wb_done pulses once; 16 features consumed.
- Rounding/saturation: shift=4.
  - Inputs 24 -> 2 (24+8=32, >>4).
  - -24 -> -1 (-24+8=-16, >>4).
  - 0x7FFF_FFFF -> 0x7FFF.
  - 0x8000_0000 -> 0x8000.
  - relu_en=1 makes -24 -> 0.
- Backpressure: o_wr_ready=0 for 40 cycles, word_count=6.
  - Required: exactly 4 words are packed.
  - in_ready drops after 32 features.
  - o_wr_data/o_wr_addr remain stable.
  - After release, all 6 words are written in order with correct addresses.
- Boundaries:
  - word_count=0 -> wb_done the cycle after start, no writes.
  - dst_addr=0xFFFF, word_count=2 -> addresses 0xFFFF then 0x0000.
  - wb_enable during RUN is ignored.
- Reset mid-run: assert rst=0 after 3 lanes of word 1.
  - Required: all outputs 0 immediately (async); FIFO is empty.
  - A new start then writes from the new dst_addr with lane 0 fresh.
